// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the data-memory strobes and hands write-back data to MEM/WB.
// Optional load/store performance counters are enabled by defining MEM_STAGE_PERF_EN.
module mem_access_stage #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_reg_write,
  output logic              Write_Enable,
  output logic [ADDR_W-1:0] rW_Addr,
  output logic [DATA_W-1:0] rW_Data,
  output logic              Read_Enable,
  output logic [ADDR_W-1:0] rR_Addr,
  input  logic [DATA_W-1:0] rR_Data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_wb_data,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_reg_write,
`ifdef MEM_STAGE_PERF_EN
  output logic [31:0]       load_count,
  output logic [31:0]       store_count,
`endif
  output logic              err_flag
);

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  state_t state, nextState;
  logic   accept;
  logic   isLoad;

  // A simultaneous read+write request is treated as a store; the load is dropped.
  assign isLoad  = in_mem_read && !in_mem_write;
  assign rW_Addr = in_addr;
  assign rW_Data = in_wdata;
  assign rR_Addr = in_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState    = state;
    in_ready     = 1'b0;
    accept       = 1'b0;
    Write_Enable = 1'b0;
    Read_Enable  = 1'b0;
    case (state)
      IDLE: begin
        in_ready     = !out_valid || out_ready;
        accept       = in_valid && in_ready && !reset;
        Write_Enable = accept && in_mem_write;
        Read_Enable  = accept && isLoad;
        if (accept && isLoad) nextState = LOAD_WAIT;
      end
      LOAD_WAIT: nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_wb_data   <= '0;
      out_rd        <= '0;
      out_reg_write <= 1'b0;
      err_flag      <= 1'b0;
    end else begin
      if (accept && in_mem_read && in_mem_write) err_flag <= 1'b1;
      if (state == LOAD_WAIT) begin
        out_valid   <= 1'b1;
        out_wb_data <= rR_Data;
      end else if (accept) begin
        // Loads latch the destination now and publish data one cycle later.
        out_valid     <= !isLoad;
        out_rd        <= in_rd;
        out_reg_write <= in_reg_write;
        if (!isLoad) out_wb_data <= in_alu_result;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MEM_STAGE_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_count  <= '0;
      store_count <= '0;
    end else begin
      if (Read_Enable && load_count != 32'hFFFF_FFFF)   load_count  <= load_count + 32'd1;
      if (Write_Enable && store_count != 32'hFFFF_FFFF) store_count <= store_count + 32'd1;
    end
  end
`endif

endmodule
